// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and memory stages.
// Ports:
//    clk, reset                     clock, synchronous active-high reset
//    IReq/IAddr/FlushF              fetch request, address, fetch flush
//    DReq/DWe/DAddr/DWdata          data request, write enable, address, data
//    MemReq/MemWe/MemAddr/MemWdata  registered memory request bus
//    MemRdata/MemReady              memory read data and completion strobe
//    IRdata/IValid, DRdata/DValid   per-requester result and one-cycle strobe
//    StallF/StallM                  combinational stage holds
//    MemErr                         sticky watchdog timeout flag
module mem_port_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        IReq,
   input  logic [31:0] IAddr,
   input  logic        FlushF,
   input  logic        DReq,
   input  logic        DWe,
   input  logic [31:0] DAddr,
   input  logic [31:0] DWdata,
   output logic        MemReq,
   output logic        MemWe,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWdata,
   input  logic [31:0] MemRdata,
   input  logic        MemReady,
   output logic [31:0] IRdata,
   output logic        IValid,
   output logic [31:0] DRdata,
   output logic        DValid,
   output logic        StallF,
   output logic        StallM,
   output logic        MemErr
);

   typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

   state_t      r_state;
   logic        r_drop;
   logic [7:0]  r_wd;
   logic        r_memreq;
   logic        r_memwe;
   logic [31:0] r_memaddr;
   logic [31:0] r_memwdata;
   logic [31:0] r_irdata;
   logic [31:0] r_drdata;
   logic        r_ivalid;
   logic        r_dvalid;
   logic        r_memerr;

   logic        w_free;
   logic        w_dgnt;
   logic        w_ignt;
   logic        w_tmo;

   // The completion cycle is a dead cycle for arbitration, so a
   // requester still holding its request there is never re-granted.
   assign w_free = ~r_ivalid & ~r_dvalid;
   assign w_dgnt = DReq & w_free;
   assign w_ignt = IReq & ~FlushF & w_free;
   assign w_tmo  = ~MemReady & (r_wd == 8'hFF);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_drop     <= 1'b0;
         r_wd       <= 8'h00;
         r_memreq   <= 1'b0;
         r_memwe    <= 1'b0;
         r_memaddr  <= 32'h0;
         r_memwdata <= 32'h0;
         r_irdata   <= 32'h0;
         r_drdata   <= 32'h0;
         r_ivalid   <= 1'b0;
         r_dvalid   <= 1'b0;
         r_memerr   <= 1'b0;
      end else begin
         r_ivalid <= 1'b0;
         r_dvalid <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_dgnt) begin
                  r_state    <= DBUSY;
                  r_memreq   <= 1'b1;
                  r_memwe    <= DWe;
                  r_memaddr  <= DAddr;
                  r_memwdata <= DWdata;
                  r_wd       <= 8'h00;
               end else if (w_ignt) begin
                  r_state   <= IBUSY;
                  r_memreq  <= 1'b1;
                  r_memwe   <= 1'b0;
                  r_memaddr <= IAddr;
                  r_wd      <= 8'h00;
               end
            end
            DBUSY: begin
               if (MemReady) begin
                  r_state  <= IDLE;
                  r_memreq <= 1'b0;
                  r_dvalid <= 1'b1;
                  // Stores leave the last load result visible.
                  if (!r_memwe)
                     r_drdata <= MemRdata;
               end else if (w_tmo) begin
                  r_state  <= IDLE;
                  r_memreq <= 1'b0;
                  r_dvalid <= 1'b1;
                  r_drdata <= 32'h0;
                  r_memerr <= 1'b1;
                  r_drop   <= 1'b0;
               end else begin
                  r_wd <= r_wd + 8'h01;
               end
            end
            IBUSY: begin
               if (FlushF)
                  r_drop <= 1'b1;
               if (MemReady) begin
                  r_state  <= IDLE;
                  r_memreq <= 1'b0;
                  r_drop   <= 1'b0;
                  if (!r_drop) begin
                     r_ivalid <= 1'b1;
                     r_irdata <= MemRdata;
                  end
               end else if (w_tmo) begin
                  r_state  <= IDLE;
                  r_memreq <= 1'b0;
                  r_memerr <= 1'b1;
                  r_drop   <= 1'b0;
                  if (!r_drop) begin
                     r_ivalid <= 1'b1;
                     r_irdata <= 32'h0;
                  end
               end else begin
                  r_wd <= r_wd + 8'h01;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_memreq <= 1'b0;
            end
         endcase
      end
   end

   assign MemReq   = r_memreq;
   assign MemWe    = r_memwe;
   assign MemAddr  = r_memaddr;
   assign MemWdata = r_memwdata;
   assign IRdata   = r_irdata;
   assign IValid   = r_ivalid;
   assign DRdata   = r_drdata;
   assign DValid   = r_dvalid;
   assign MemErr   = r_memerr;
   assign StallM   = DReq & ~r_dvalid;
   assign StallF   = IReq & ~r_ivalid & ~FlushF;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios push expected
// completions; a negedge monitor pops and compares on IValid/DValid.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        IReq;
   logic [31:0] IAddr;
   logic        FlushF;
   logic        DReq;
   logic        DWe;
   logic [31:0] DAddr;
   logic [31:0] DWdata;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWdata;
   logic [31:0] MemRdata;
   logic        MemReady;
   logic [31:0] IRdata;
   logic        IValid;
   logic [31:0] DRdata;
   logic        DValid;
   logic        StallF;
   logic        StallM;
   logic        MemErr;

   mem_port_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .IReq     (IReq),
      .IAddr    (IAddr),
      .FlushF   (FlushF),
      .DReq     (DReq),
      .DWe      (DWe),
      .DAddr    (DAddr),
      .DWdata   (DWdata),
      .MemReq   (MemReq),
      .MemWe    (MemWe),
      .MemAddr  (MemAddr),
      .MemWdata (MemWdata),
      .MemRdata (MemRdata),
      .MemReady (MemReady),
      .IRdata   (IRdata),
      .IValid   (IValid),
      .DRdata   (DRdata),
      .DValid   (DValid),
      .StallF   (StallF),
      .StallM   (StallM),
      .MemErr   (MemErr)
   );

   typedef struct {
      bit          is_i;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   task automatic push(input bit is_i, input logic [31:0] d, input int c);
      exp_t e;
      e.is_i = is_i;
      e.data = d;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   // Monitor: every completion strobe must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] got;
      if (IValid || DValid) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: IValid=%0b DValid=%0b at cycle %0d",
                     IValid, DValid, cyc);
         end else begin
            e = sb.pop_front();
            got = IValid ? IRdata : DRdata;
            if ((IValid !== e.is_i) || (DValid === e.is_i) ||
                (got !== e.data) || (cyc != e.cyc)) begin
               n_fail++;
               $display("FAIL sb_%s: actual I=%0b D=%0b data=%h cyc=%0d required data=%h cyc=%0d",
                        e.is_i ? "fetch" : "data", IValid, DValid, got, cyc,
                        e.data, e.cyc);
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_MemReq"},   MemReq,   0);
      check({tag, "_MemWe"},    MemWe,    0);
      check({tag, "_MemAddr"},  MemAddr,  0);
      check({tag, "_MemWdata"}, MemWdata, 0);
      check({tag, "_IRdata"},   IRdata,   0);
      check({tag, "_DRdata"},   DRdata,   0);
      check({tag, "_IValid"},   IValid,   0);
      check({tag, "_DValid"},   DValid,   0);
      check({tag, "_MemErr"},   MemErr,   0);
   endtask

   initial begin
      reset = 1'b1;
      IReq = 0; IAddr = 0; FlushF = 0;
      DReq = 0; DWe = 0; DAddr = 0; DWdata = 0;
      MemRdata = 0; MemReady = 0;
      tick();
      tick();
      check_zero("rst");
      reset = 1'b0;

      // Single fetch, 2-cycle memory
      tick(); b = cyc;
      IReq = 1; IAddr = 32'h100;
      push(1, 32'hE3A01005, b + 3);
      #1;
      check("f_stall0", StallF, 1);
      check("f_req0", MemReq, 0);
      tick();
      check("f_req1", MemReq, 1);
      check("f_addr", MemAddr, 32'h100);
      check("f_we", MemWe, 0);
      check("f_stall1", StallF, 1);
      tick();
      MemReady = 1; MemRdata = 32'hE3A01005;
      #1;
      check("f_req2", MemReq, 1);
      check("f_stall2", StallF, 1);
      tick();
      MemReady = 0;
      #1;
      check("f_ivalid3", IValid, 1);
      check("f_stall3", StallF, 0);
      check("f_req3", MemReq, 0);
      tick();
      IReq = 0;

      // Simultaneous requests, data wins
      tick(); b = cyc;
      IReq = 1; IAddr = 32'h104;
      DReq = 1; DWe = 1; DAddr = 32'h200; DWdata = 32'h55;
      MemReady = 1; MemRdata = 32'hDEADBEEF;
      push(0, 32'h0, b + 2);
      push(1, 32'hDEADBEEF, b + 5);
      tick();
      check("s_req1", MemReq, 1);
      check("s_we1", MemWe, 1);
      check("s_addr1", MemAddr, 32'h200);
      check("s_wdata1", MemWdata, 32'h55);
      check("s_stallf1", StallF, 1);
      check("s_stallm1", StallM, 1);
      tick();
      check("s_stallm2", StallM, 0);
      tick();
      DReq = 0;
      #1;
      check("s_req3", MemReq, 0);
      tick();
      check("s_req4", MemReq, 1);
      check("s_addr4", MemAddr, 32'h104);
      check("s_we4", MemWe, 0);
      check("s_wdata4", MemWdata, 32'h55);
      tick();
      check("s_ivalid5", IValid, 1);
      tick();
      IReq = 0; MemReady = 0;

      // Load
      tick(); b = cyc;
      DReq = 1; DWe = 0; DAddr = 32'h600; MemReady = 1;
      MemRdata = 32'hA5A5A5A5;
      push(0, 32'hA5A5A5A5, b + 2);
      tick();
      check("l_we1", MemWe, 0);
      check("l_addr1", MemAddr, 32'h600);
      tick();
      tick();
      DReq = 0; MemReady = 0;

      // Flush in flight
      tick(); b = cyc;
      IReq = 1; IAddr = 32'h300;
      tick();
      tick();
      FlushF = 1;
      #1;
      check("x_stallf2", StallF, 0);
      tick();
      FlushF = 0; IAddr = 32'h400;
      MemReady = 1; MemRdata = 32'h12345678;
      tick();
      MemReady = 0;
      #1;
      check("x_ivalid4", IValid, 0);
      check("x_req4", MemReq, 0);
      check("x_irdata4", IRdata, 32'hDEADBEEF);
      push(1, 32'hCAFEF00D, b + 6);
      tick();
      check("x_req5", MemReq, 1);
      check("x_addr5", MemAddr, 32'h400);
      MemReady = 1; MemRdata = 32'hCAFEF00D;
      tick();
      MemReady = 0;
      tick();
      IReq = 0;

      // Watchdog timeout on a load
      tick(); b = cyc;
      DReq = 1; DWe = 0; DAddr = 32'h500;
      push(0, 32'h0, b + 257);
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 1 || i == 256) begin
            check($sformatf("w_req%0d", i), MemReq, 1);
            check($sformatf("w_err%0d", i), MemErr, 0);
         end
      end
      tick();
      check("w_err257", MemErr, 1);
      check("w_req257", MemReq, 0);
      tick();
      DReq = 0;
      tick();
      check("w_sticky", MemErr, 1);

      // Reset during DBUSY
      tick(); b = cyc;
      DReq = 1; DWe = 1; DAddr = 32'h700; DWdata = 32'h77;
      tick();
      check("r_req1", MemReq, 1);
      tick();
      reset = 1; DReq = 0;
      tick();
      reset = 0; MemReady = 1; MemRdata = 32'h99;
      #1;
      check_zero("rmid");
      check("r_stallm", StallM, 0);
      tick();
      check("r_req4", MemReq, 0);
      MemReady = 0;
      DReq = 1; DWe = 0; DAddr = 32'h800;
      push(0, 32'h11, b + 6);
      tick();
      check("r_req5", MemReq, 1);
      check("r_addr5", MemAddr, 32'h800);
      MemReady = 1; MemRdata = 32'h11;
      tick();
      MemReady = 0;
      tick();
      DReq = 0;
      repeat (4) tick();

      check("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
